spi_target: RTL and testbench

SPI mode-0 target (peripheral) that lets an external SPI controller exchange bytes with the core over the shared-bus pin set (cs/sclk/mosi in, miso out). It is the counterpart of the SPI initiator path that drives the NFC and EEPROM chip selects. It oversamples the pins with the system clock, deserialises MOSI into bytes, and serialises a one-entry transmit holding register onto MISO. It sits between the input pads and a byte-level consumer, for example a configuration register file.

---
 rtl/spi_target_if.sv | 35 +++
 rtl/spi_target.sv | 168 ++++++++++++++++
 tb/tb_spi_target.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_if.sv
// Pin-level and byte-level signal bundle for the SPI mode-0 target.
// The slave modport is the target's view; the master modport is the view of
// whatever drives the pads and consumes/produces bytes around it.
interface spi_target_if;
   // SPI pad side
   logic       spi_cs_n;
   logic       spi_sclk;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_miso_oe;
   // Byte side
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_underrun;
   // Frame status
   logic       frame_start;
   logic       frame_end;
   logic       frame_err;
   logic       busy;

   modport slave (
      input  spi_cs_n, spi_sclk, spi_mosi, tx_data, tx_valid,
      output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, tx_underrun,
             frame_start, frame_end, frame_err, busy
   );

   modport master (
      output spi_cs_n, spi_sclk, spi_mosi, tx_data, tx_valid,
      input  spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, tx_underrun,
             frame_start, frame_end, frame_err, busy
   );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target. The pads are oversampled by clk through synchroniser
// chains, edges become registered one-cycle strobes, and a two-state FSM
// deserialises MOSI and serialises a one-entry transmit holding register onto
// MISO. SYNC_STAGES must be 2 or 3.
module spi_target #(
   parameter int SYNC_STAGES = 2
) (
   input logic         clk,
   input logic         rst_n,
   spi_target_if.slave bus
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   // Synchroniser chains; the last stage is the synchronised pin value.
   logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
   logic                   cs_s, sclk_s, mosi_s;

   // History flops and registered edge strobes.
   logic cs_hist, sclk_hist, mosi_smp;
   logic cs_fall, cs_rise, sclk_rise, sclk_fall;

   // Core state.
   state_t     state;
   logic [2:0] bit_cnt;
   logic [6:0] rx_shift;
   logic [7:0] tx_shift;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       load_pending;
   logic [7:0] hold_data;
   logic       hold_full;
   logic       tx_underrun;
   logic       frame_start, frame_end, frame_err;
   logic       do_load;

   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Pin synchronisers; cs_n resets to the deselected level so reset never looks like a CS fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      end
   end

   // Edge detection; mosi is delayed alongside so it lines up with the sclk-rise strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_hist   <= 1'b1;
         sclk_hist <= 1'b0;
         mosi_smp  <= 1'b0;
         cs_fall   <= 1'b0;
         cs_rise   <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
      end else begin
         cs_hist   <= cs_s;
         sclk_hist <= sclk_s;
         mosi_smp  <= mosi_s;
         cs_fall   <= cs_hist & ~cs_s;
         cs_rise   <= ~cs_hist & cs_s;
         sclk_rise <= ~sclk_hist & sclk_s;
         sclk_fall <= sclk_hist & ~sclk_s;
      end
   end

   // A TX load happens at frame start and on the first sclk fall after a completed byte.
   assign do_load = ((state == IDLE) && cs_fall) ||
                    ((state == ACTIVE) && !cs_rise && sclk_fall && load_pending);

   // Frame FSM, shift registers and transmit holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bit_cnt      <= 3'd0;
         rx_shift     <= 7'd0;
         tx_shift     <= 8'hFF;
         rx_data      <= 8'h00;
         rx_valid     <= 1'b0;
         load_pending <= 1'b0;
         // NOTE: hold_data is reset only for determinism; hold_full alone decides whether it is used.
         hold_data    <= 8'h00;
         hold_full    <= 1'b0;
         tx_underrun  <= 1'b0;
         frame_start  <= 1'b0;
         frame_end    <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         frame_err   <= 1'b0;

         if (bus.tx_valid && !hold_full) begin
            hold_data <= bus.tx_data;
            hold_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (cs_fall) begin
                  frame_start <= 1'b1;
                  bit_cnt     <= 3'd0;
                  state       <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  frame_end    <= 1'b1;
                  frame_err    <= (bit_cnt != 3'd0);
                  rx_shift     <= 7'd0;
                  load_pending <= 1'b0;
                  state        <= IDLE;
               end else if (sclk_rise) begin
                  rx_shift <= {rx_shift[5:0], mosi_smp};
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rx_data      <= {rx_shift, mosi_smp};
                     rx_valid     <= 1'b1;
                     load_pending <= 1'b1;
                  end
               end else if (sclk_fall) begin
                  if (load_pending) begin
                     load_pending <= 1'b0;
                  end else begin
                     tx_shift <= {tx_shift[6:0], 1'b1};
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // The load sits after the accept so an empty-register load wins over nothing and
         // a same-cycle accept still leaves its byte held for the next slot.
         if (do_load) begin
            if (hold_full) begin
               tx_shift  <= hold_data;
               hold_full <= 1'b0;
            end else begin
               tx_shift    <= 8'hFF;
               tx_underrun <= 1'b1;
            end
         end
      end
   end

   assign bus.spi_miso    = tx_shift[7];
   assign bus.spi_miso_oe = ~cs_s;
   assign bus.rx_data     = rx_data;
   assign bus.rx_valid    = rx_valid;
   assign bus.tx_ready    = ~hold_full;
   assign bus.tx_underrun = tx_underrun;
   assign bus.frame_start = frame_start;
   assign bus.frame_end   = frame_end;
   assign bus.frame_err   = frame_err;
   assign bus.busy        = (state == ACTIVE);

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: table of single-byte frames plus
// hand-written sequences for bursts, underrun timing, aborted bytes,
// minimum sclk phase width and mid-frame reset.
module tb_spi_target;
   localparam int SS       = 3;
   localparam int HALF_MIN = SS + 3;
   localparam int HALF_NOM = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_target_if bus ();

   spi_target #(.SYNC_STAGES(SS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   // Pulse counters, sampled on the falling clock edge.
   int n_rx = 0, n_under = 0, n_fs = 0, n_fe = 0, n_ferr = 0, n_err_end = 0;
   logic [7:0] rx_log[$];
   logic [7:0] mosi_q[$];
   logic [7:0] miso_q[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rx_valid) begin
            n_rx++;
            rx_log.push_back(bus.rx_data);
         end
         if (bus.tx_underrun) n_under++;
         if (bus.frame_start) n_fs++;
         if (bus.frame_end)   n_fe++;
         if (bus.frame_err)   n_ferr++;
         if (bus.frame_err && bus.frame_end) n_err_end++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Offer one byte on the holding-register handshake; called on a falling edge.
   task automatic offer(input logic [7:0] b);
      int t = 0;
      while (bus.tx_ready !== 1'b1 && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("offer tx_ready", {31'd0, bus.tx_ready}, 32'd1);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   // Mode-0 controller: MOSI changes with sclk low, MISO is sampled just before each
   // rise, and the final sclk fall coincides with CS rising. abort_bits>0 truncates.
   task automatic spi_frame(input int nbytes, input int half, input int abort_bits);
      int total;
      logic [7:0] mb, rb;
      total = (abort_bits > 0) ? abort_bits : nbytes * 8;
      rb = 8'h00;
      mb = 8'h00;
      bus.spi_cs_n = 1'b0;
      for (int k = 0; k < total; k++) begin
         int i;
         i = 7 - (k % 8);
         if (i == 7) mb = mosi_q[k / 8];
         bus.spi_mosi = mb[i];
         repeat (half) @(negedge clk);
         rb[i] = bus.spi_miso;
         if (k == 0) begin
            check("busy in frame", {31'd0, bus.busy}, 32'd1);
            check("miso_oe in frame", {31'd0, bus.spi_miso_oe}, 32'd1);
         end
         bus.spi_sclk = 1'b1;
         repeat (half) @(negedge clk);
         bus.spi_sclk = 1'b0;
         if (k == total - 1) bus.spi_cs_n = 1'b1;
         if (i == 0) miso_q.push_back(rb);
      end
      repeat (12) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] mosi;
      logic       preload;
      logic [7:0] tx;
      logic [7:0] exp_miso;
      int         exp_under;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int rx0, un0, fs0, fe0, fe_err0, ee0, base;
      logic [7:0] rnd_tx[4];
      logic [7:0] rnd_rx[4];

      vecs[0] = '{mosi: 8'hA5, preload: 1'b1, tx: 8'hC3, exp_miso: 8'hC3, exp_under: 0};
      vecs[1] = '{mosi: 8'h00, preload: 1'b1, tx: 8'hFF, exp_miso: 8'hFF, exp_under: 0};
      vecs[2] = '{mosi: 8'hFF, preload: 1'b1, tx: 8'h00, exp_miso: 8'h00, exp_under: 0};
      vecs[3] = '{mosi: 8'h3C, preload: 1'b0, tx: 8'h00, exp_miso: 8'hFF, exp_under: 1};
      vecs[4] = '{mosi: 8'h81, preload: 1'b1, tx: 8'h6D, exp_miso: 8'h6D, exp_under: 0};

      bus.spi_cs_n = 1'b1;
      bus.spi_sclk = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      repeat (3) @(negedge clk);

      // Reset values while held in reset.
      check("reset miso",     {31'd0, bus.spi_miso},    32'd1);
      check("reset miso_oe",  {31'd0, bus.spi_miso_oe}, 32'd0);
      check("reset rx_data",  {24'd0, bus.rx_data},     32'h00);
      check("reset tx_ready", {31'd0, bus.tx_ready},    32'd1);
      check("reset busy",     {31'd0, bus.busy},        32'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Table of single-byte frames.
      for (int v = 0; v < 5; v++) begin
         if (vecs[v].preload) offer(vecs[v].tx);
         mosi_q = {vecs[v].mosi};
         miso_q = {};
         rx0 = n_rx; un0 = n_under; fs0 = n_fs; fe0 = n_fe; fe_err0 = n_ferr;
         spi_frame(1, HALF_NOM, 0);
         check($sformatf("v%0d miso byte", v), {24'd0, miso_q[0]}, {24'd0, vecs[v].exp_miso});
         check($sformatf("v%0d rx_data", v), {24'd0, bus.rx_data}, {24'd0, vecs[v].mosi});
         check($sformatf("v%0d rx_valid count", v), n_rx - rx0, 1);
         check($sformatf("v%0d underrun count", v), n_under - un0, vecs[v].exp_under);
         check($sformatf("v%0d frame_start count", v), n_fs - fs0, 1);
         check($sformatf("v%0d frame_end count", v), n_fe - fe0, 1);
         check($sformatf("v%0d frame_err count", v), n_ferr - fe_err0, 0);
         check($sformatf("v%0d tx_ready after", v), {31'd0, bus.tx_ready}, 32'd1);
         check($sformatf("v%0d busy after", v), {31'd0, bus.busy}, 32'd0);
         check($sformatf("v%0d miso_oe after", v), {31'd0, bus.spi_miso_oe}, 32'd0);
      end

      // Three-byte burst with the feeder refilling as soon as tx_ready rises.
      offer(8'h11);
      mosi_q = {8'h01, 8'h02, 8'h03};
      miso_q = {};
      base = rx_log.size();
      un0 = n_under;
      fork
         spi_frame(3, HALF_NOM, 0);
         begin
            offer(8'h22);
            offer(8'h33);
         end
      join
      check("burst miso0", {24'd0, miso_q[0]}, 32'h11);
      check("burst miso1", {24'd0, miso_q[1]}, 32'h22);
      check("burst miso2", {24'd0, miso_q[2]}, 32'h33);
      check("burst rx count", rx_log.size() - base, 3);
      check("burst rx0", {24'd0, rx_log[base]},     32'h01);
      check("burst rx1", {24'd0, rx_log[base + 1]}, 32'h02);
      check("burst rx2", {24'd0, rx_log[base + 2]}, 32'h03);
      check("burst underrun count", n_under - un0, 0);

      // Underrun: empty register for two bytes, 0x7E offered in the second load's cycle.
      mosi_q = {8'h96, 8'h69};
      miso_q = {};
      un0 = n_under;
      fork
         spi_frame(2, HALF_NOM, 0);
         begin
            int t = 0;
            while (bus.rx_valid !== 1'b1 && t < 1000) begin
               @(negedge clk);
               t++;
            end
            check("underrun bit7 seen", {31'd0, bus.rx_valid}, 32'd1);
            repeat (HALF_NOM - 1) @(negedge clk);
            bus.tx_data  = 8'h7E;
            bus.tx_valid = 1'b1;
            @(negedge clk);
            bus.tx_valid = 1'b0;
            check("underrun with accept", {31'd0, bus.tx_underrun}, 32'd1);
            check("accept during load",   {31'd0, bus.tx_ready},    32'd0);
         end
      join
      check("underrun miso0", {24'd0, miso_q[0]}, 32'hFF);
      check("underrun miso1", {24'd0, miso_q[1]}, 32'hFF);
      check("underrun count", n_under - un0, 2);
      check("held across frame", {31'd0, bus.tx_ready}, 32'd0);
      mosi_q = {8'h00};
      miso_q = {};
      un0 = n_under;
      spi_frame(1, HALF_NOM, 0);
      check("held byte sent", {24'd0, miso_q[0]}, 32'h7E);
      check("held byte no underrun", n_under - un0, 0);

      // Aborted byte after five bits, then a clean frame.
      mosi_q = {8'hFF};
      miso_q = {};
      rx0 = n_rx; fe0 = n_fe; fe_err0 = n_ferr; ee0 = n_err_end;
      spi_frame(1, HALF_NOM, 5);
      check("abort frame_end count", n_fe - fe0, 1);
      check("abort frame_err count", n_ferr - fe_err0, 1);
      check("abort err with end", n_err_end - ee0, 1);
      check("abort no rx_valid", n_rx - rx0, 0);
      mosi_q = {8'h81};
      miso_q = {};
      rx0 = n_rx; fe_err0 = n_ferr;
      spi_frame(1, HALF_NOM, 0);
      check("after abort rx_data", {24'd0, bus.rx_data}, 32'h81);
      check("after abort rx count", n_rx - rx0, 1);
      check("after abort no err", n_ferr - fe_err0, 0);

      // Minimum sclk phase width with random bytes against a queue model.
      for (int i = 0; i < 4; i++) begin
         rnd_tx[i] = 8'($urandom_range(0, 255));
         rnd_rx[i] = 8'($urandom_range(0, 255));
      end
      offer(rnd_tx[0]);
      mosi_q = {rnd_rx[0], rnd_rx[1], rnd_rx[2], rnd_rx[3]};
      miso_q = {};
      base = rx_log.size();
      un0 = n_under;
      fork
         spi_frame(4, HALF_MIN, 0);
         begin
            for (int i = 1; i < 4; i++) offer(rnd_tx[i]);
         end
      join
      check("min rx count", rx_log.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("min miso%0d", i), {24'd0, miso_q[i]}, {24'd0, rnd_tx[i]});
         check($sformatf("min rx%0d", i), {24'd0, rx_log[base + i]}, {24'd0, rnd_rx[i]});
      end
      check("min underrun count", n_under - un0, 0);

      // Mid-frame reset: MISO driven low and a byte held so reset visibly changes them.
      offer(8'h00);
      bus.spi_cs_n = 1'b0;
      repeat (HALF_NOM) @(negedge clk);
      offer(8'h99);
      for (int i = 0; i < 3; i++) begin
         bus.spi_mosi = 1'b1;
         bus.spi_sclk = 1'b1;
         repeat (HALF_NOM) @(negedge clk);
         bus.spi_sclk = 1'b0;
         repeat (HALF_NOM) @(negedge clk);
      end
      check("pre-reset miso",     {31'd0, bus.spi_miso}, 32'd0);
      check("pre-reset tx_ready", {31'd0, bus.tx_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid reset miso",        {31'd0, bus.spi_miso},    32'd1);
      check("mid reset miso_oe",     {31'd0, bus.spi_miso_oe}, 32'd0);
      check("mid reset rx_data",     {24'd0, bus.rx_data},     32'h00);
      check("mid reset rx_valid",    {31'd0, bus.rx_valid},    32'd0);
      check("mid reset tx_ready",    {31'd0, bus.tx_ready},    32'd1);
      check("mid reset busy",        {31'd0, bus.busy},        32'd0);
      check("mid reset frame_start", {31'd0, bus.frame_start}, 32'd0);
      check("mid reset frame_end",   {31'd0, bus.frame_end},   32'd0);
      check("mid reset frame_err",   {31'd0, bus.frame_err},   32'd0);
      check("mid reset underrun",    {31'd0, bus.tx_underrun}, 32'd0);
      @(negedge clk);
      bus.spi_cs_n = 1'b1;
      bus.spi_sclk = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      mosi_q = {8'h5A};
      miso_q = {};
      rx0 = n_rx;
      spi_frame(1, HALF_NOM, 0);
      check("post reset rx count", n_rx - rx0, 1);
      check("post reset rx_data", {24'd0, bus.rx_data}, 32'h5A);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
